audio_dac_serializer: RTL and testbench

- Downstream stage of the echo datapath: takes each 16-bit processed sample on the system clock and serializes it to the audio codec DAC in I2S format.
- The codec is bit-clock and frame-clock master. The block synchronizes BCLK/LRCLK into the `clk` domain and shifts `dacdat` on detected BCLK falling edges.
- A one-entry holding buffer with a valid/ready handshake decouples the sample producer from frame timing.

---
 rtl/audio_dac_serializer.sv | 143 ++++++++++++++
 tb/tb_audio_dac_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: one-entry sample buffer, BCLK/LRCLK synchronizers and a shift FSM.
// Define STEREO_DUP_EN to repeat the left sample in the right slot; otherwise the right slot is silent.
module audio_dac_serializer #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     bclk,
  input  logic                     lrclk,
  output logic                     dacdat,
  output logic                     frame_start,
  output logic                     underrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  logic [SYNC_STAGES-1:0]    bclk_sync, lrclk_sync;
  logic                      bclk_hist, lrclk_hist;
  logic                      bclk_fall, lr_fall, lr_rise;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  hold_reg, hold_reg_nxt;
  logic                      hold_full, hold_full_nxt;
  logic signed [DATA_W-1:0]  last_sample, last_sample_nxt;
  logic signed [DATA_W-1:0]  shift_reg, shift_reg_nxt;
  logic signed [DATA_W-1:0]  right_word;
  logic [CNT_W-1:0]          bit_cnt, bit_cnt_nxt;
  logic                      dacdat_nxt, frame_start_nxt, underrun_nxt;

  // Stage: codec clock synchronizers plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      bclk_hist  <= 1'b0;
      lrclk_hist <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      bclk_hist  <= bclk_sync[SYNC_STAGES-1];
      lrclk_hist <= lrclk_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_fall    = bclk_hist & ~bclk_sync[SYNC_STAGES-1];
  assign lr_fall      = lrclk_hist & ~lrclk_sync[SYNC_STAGES-1];
  assign lr_rise      = ~lrclk_hist & lrclk_sync[SYNC_STAGES-1];
  assign sample_ready = ~hold_full;

`ifdef STEREO_DUP_EN
  assign right_word = last_sample;
`else
  assign right_word = '0;
`endif

  // Stage: handshake, frame load and serial shift decisions
  always_comb begin
    state_nxt       = state;
    hold_reg_nxt    = hold_reg;
    hold_full_nxt   = hold_full;
    last_sample_nxt = last_sample;
    shift_reg_nxt   = shift_reg;
    bit_cnt_nxt     = bit_cnt;
    dacdat_nxt      = dacdat;
    frame_start_nxt = 1'b0;
    underrun_nxt    = 1'b0;

    if (sample_valid && !hold_full) begin
      hold_reg_nxt  = sample_in;
      hold_full_nxt = 1'b1;
    end

    // A frame edge wins over any bit edge and abandons a partly sent word.
    if (lr_fall) begin
      if (hold_full) begin
        last_sample_nxt = hold_reg;
        hold_full_nxt   = 1'b0;
      end else begin
        underrun_nxt    = 1'b1;
      end
      shift_reg_nxt   = last_sample_nxt;
      frame_start_nxt = 1'b1;
      state_nxt       = DELAY;
    end else if (lr_rise) begin
      shift_reg_nxt = right_word;
      state_nxt     = DELAY;
    end else if (bclk_fall) begin
      case (state)
        IDLE:  dacdat_nxt = 1'b0;
        DELAY: begin
          dacdat_nxt    = shift_reg[DATA_W-1];
          shift_reg_nxt = {shift_reg[DATA_W-2:0], 1'b0};
          bit_cnt_nxt   = '0;
          state_nxt     = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == CNT_W'(DATA_W-1)) begin
            dacdat_nxt = 1'b0;
            state_nxt  = PAD;
          end else begin
            dacdat_nxt    = shift_reg[DATA_W-1];
            shift_reg_nxt = {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt_nxt   = bit_cnt + 1'b1;
          end
        end
        PAD:     dacdat_nxt = 1'b0;
        default: state_nxt  = IDLE;
      endcase
    end
  end

  // Stage: registered state and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      last_sample <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      dacdat      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_reg    <= hold_reg_nxt;
      hold_full   <= hold_full_nxt;
      last_sample <= last_sample_nxt;
      shift_reg   <= shift_reg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      dacdat      <= dacdat_nxt;
      frame_start <= frame_start_nxt;
      underrun    <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: acts as codec clock master (bclk = 16 clk, 32 slots per channel)
// and captures dacdat just before each bclk rising edge.
module tb_audio_dac_serializer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;
  logic               bclk;
  logic               lrclk;
  logic               dacdat;
  logic               frame_start;
  logic               underrun;

  int vectors     = 0;
  int miscompares = 0;
  int fs_cnt      = 0;
  int ur_cnt      = 0;

  logic [15:0] mdl_q[$];
  logic [15:0] mdl_last;

  typedef struct {
    logic        offer;
    logic [15:0] smp;
    logic [31:0] exp_l;
    logic        exp_u;
  } vec_t;

  vec_t tbl[6];

  audio_dac_serializer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .dacdat       (dacdat),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (underrun)    ur_cnt <= ur_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_word(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  function automatic logic [31:0] right_of(input logic [31:0] left);
`ifdef STEREO_DUP_EN
    return left;
`else
    return 32'h0 & left;
`endif
  endfunction

  task automatic offer(input logic [15:0] v);
    bit done;
    done = 1'b0;
    sample_in    = v;
    sample_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    sample_valid = 1'b0;
    chk("offer_accepted", 32'(done), 32'd1);
  endtask

  // One bclk period: falling edge (with lrclk change), sample dacdat late in the low phase.
  task automatic run_slot(input logic lr, input logic inj, input logic [15:0] iv, output logic b);
    time t0;
    t0    = $time;
    lrclk = lr;
    bclk  = 1'b0;
    if (inj) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      sample_in    = iv;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      chk("simul_ready_low", 32'(sample_ready), 32'd0);
    end
    #(t0 + 79 - $time);
    b = dacdat;
    #1;
    bclk = 1'b1;
    #80;
  endtask

  task automatic run_chan(input logic lr, input int n, input logic inj, input logic [15:0] iv,
                          output logic [31:0] bits);
    logic b;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      run_slot(lr, inj && (i == 0), iv, b);
      bits = {bits[30:0], b};
    end
  endtask

  task automatic do_frame(input string tag, input logic [31:0] exp_l, input logic exp_u,
                          input logic inj, input logic [15:0] iv);
    logic [31:0] l, r;
    int fs0, ur0;
    fs0 = fs_cnt;
    ur0 = ur_cnt;
    run_chan(1'b0, 32, inj, iv, l);
    run_chan(1'b1, 32, 1'b0, 16'h0, r);
    chk({tag, "_left"}, l, exp_l);
    chk({tag, "_right"}, r, right_of(exp_l));
    chk({tag, "_frame_start"}, 32'(fs_cnt - fs0), 32'd1);
    chk({tag, "_underrun"}, 32'(ur_cnt - ur0), 32'(exp_u));
  endtask

  initial begin
    logic [31:0] bits;
    logic [15:0] v;
    logic        eu;
    int          fs0;

    tbl[0] = '{1'b1, 16'hA5C3, 32'h52E18000, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 32'h52E18000, 1'b1};
    tbl[2] = '{1'b1, 16'h8001, 32'h40008000, 1'b0};
    tbl[3] = '{1'b1, 16'h0000, 32'h00000000, 1'b0};
    tbl[4] = '{1'b1, 16'hFFFF, 32'h7FFF8000, 1'b0};
    tbl[5] = '{1'b1, 16'h1234, 32'h091A0000, 1'b0};

    reset_n      = 1'b0;
    bclk         = 1'b1;
    lrclk        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    mdl_last     = '0;
    #2;

    // Reset held while the codec clocks run
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      logic b;
      run_slot(((i / 2) % 2) == 1, 1'b0, 16'h0, b);
      bits = {bits[30:0], b};
    end
    chk("rst_dacdat", bits, 32'h0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_pulses", 32'(fs_cnt + ur_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_chan(1'b1, 4, 1'b0, 16'h0, bits);
    chk("post_release_idle", bits, 32'h0);

    // Table-driven frames
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].offer) begin
        offer(tbl[k].smp);
        mdl_q.push_back(tbl[k].smp);
      end
      if (mdl_q.size() != 0) mdl_last = mdl_q.pop_front();
      do_frame($sformatf("tbl%0d", k), tbl[k].exp_l, tbl[k].exp_u, 1'b0, 16'h0);
      chk($sformatf("tbl%0d_ready", k), 32'(sample_ready), 32'd1);
    end

    // Accept in the same cycle as the frame load with the buffer empty
    do_frame("simul", slot_word(16'h1234), 1'b1, 1'b1, 16'h7FFF);
    chk("simul_ready_after", 32'(sample_ready), 32'd0);
    do_frame("after_simul", 32'h3FFF8000, 1'b0, 1'b0, 16'h0);
    mdl_last = 16'h7FFF;

    // lrclk edge after 8 data bits truncates the word
    offer(16'hA5C3);
    fs0 = fs_cnt;
    run_chan(1'b0, 9, 1'b0, 16'h0, bits);
    chk("trunc_first8", bits, 32'h000000A5);
    chk("trunc_frame_start", 32'(fs_cnt - fs0), 32'd1);
    run_chan(1'b1, 32, 1'b0, 16'h0, bits);
    chk("trunc_restart", bits & 32'h7FFFFFFF, right_of(32'h52E18000));
    offer(16'h8001);
    do_frame("after_trunc", 32'h40008000, 1'b0, 1'b0, 16'h0);
    mdl_last = 16'h8001;

    // Asynchronous reset after five data bits
    offer(16'hFFFF);
    run_chan(1'b0, 6, 1'b0, 16'h0, bits);
    chk("midrst_first5", bits, 32'h0000001F);
    offer(16'h1234);
    chk("midrst_hold_full", 32'(sample_ready), 32'd0);
    chk("midrst_dacdat_before", 32'(dacdat), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_dacdat_async", 32'(dacdat), 32'd0);
    chk("midrst_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    mdl_q.delete();
    mdl_last = '0;
    fs0 = fs_cnt;
    run_chan(1'b1, 32, 1'b0, 16'h0, bits);
    chk("midrst_right_zero", bits, 32'h0);
    chk("midrst_no_frame", 32'(fs_cnt - fs0), 32'd0);
    do_frame("midrst_hold_cleared", 32'h0, 1'b1, 1'b0, 16'h0);

    // Randomized frames against the queue model
    for (int f = 0; f < 14; f++) begin
      if (mdl_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        v = 16'($urandom);
        offer(v);
        mdl_q.push_back(v);
      end
      if (mdl_q.size() != 0) begin
        mdl_last = mdl_q.pop_front();
        eu = 1'b0;
      end else begin
        eu = 1'b1;
      end
      do_frame($sformatf("rand%0d", f), slot_word(mdl_last), eu, 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
